// File: rtl/seq_div_unit.sv
// seq_div_unit: multi-cycle radix-2 restoring divider (DIV/DIVU/REM/REMU).
// One quotient bit per cycle; divide-by-zero and signed overflow bypass the loop.
module seq_div_unit #(
   parameter int WIDTH = 64,
   parameter int CNT_W = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             is_signed,
   input  logic             rem_sel,
   input  logic [WIDTH-1:0] op1,
   input  logic [WIDTH-1:0] op2,
   input  logic             flush,
   output logic             ready,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   state_t             state, next_state;
   logic [WIDTH-1:0]   quo, rem, dvsr;
   logic [CNT_W-1:0]   cnt;
   logic               neg_q, neg_r, rsel;

   logic               accept, div_zero, ovf;
   logic [WIDTH-1:0]   mag1, mag2;
   logic [WIDTH:0]     r_sh, diff;
   logic               take;

   assign ready    = (state == IDLE);
   assign done     = (state == DONE);
   // flush wins over start in the same cycle
   assign accept   = start & ready & ~flush;
   assign div_zero = (op2 == '0);
   assign ovf      = is_signed & (op1 == MIN_NEG) & (op2 == '1);
   assign mag1     = (is_signed & op1[WIDTH-1]) ? -op1 : op1;
   assign mag2     = (is_signed & op2[WIDTH-1]) ? -op2 : op2;

   // Trial subtract: a clear top bit of diff means the shifted remainder covers the divisor
   assign r_sh = {rem, quo[WIDTH-1]};
   assign diff = r_sh - {1'b0, dvsr};
   assign take = ~diff[WIDTH];

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= next_state;
   end

   // Next-state decode; special cases skip straight to DONE
   always_comb begin
      next_state = state;
      if (flush) begin
         next_state = IDLE;
      end else begin
         case (state)
            IDLE: if (accept) next_state = (div_zero | ovf) ? DONE : CALC;
            CALC: if (cnt == CNT_W'(1)) next_state = FIX;
            FIX:  next_state = DONE;
            DONE: next_state = IDLE;
            default: next_state = IDLE;
         endcase
      end
   end

   // Datapath: operand latch, iteration, sign fix-up and result register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         quo    <= '0;
         rem    <= '0;
         dvsr   <= '0;
         cnt    <= '0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         rsel   <= 1'b0;
         result <= '0;
      end else if (!flush) begin
         case (state)
            IDLE: if (accept) begin
               rsel <= rem_sel;
               if (div_zero)
                  result <= rem_sel ? op1 : '1;
               else if (ovf)
                  result <= rem_sel ? '0 : op1;
               else begin
                  quo   <= mag1;
                  dvsr  <= mag2;
                  rem   <= '0;
                  cnt   <= CNT_W'(WIDTH);
                  neg_q <= is_signed & (op1[WIDTH-1] ^ op2[WIDTH-1]);
                  neg_r <= is_signed & op1[WIDTH-1];
               end
            end
            CALC: begin
               quo <= {quo[WIDTH-2:0], take};
               rem <= take ? diff[WIDTH-1:0] : r_sh[WIDTH-1:0];
               cnt <= cnt - CNT_W'(1);
            end
            FIX: result <= rsel ? (neg_r ? -rem : rem) : (neg_q ? -quo : quo);
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_div_unit.sv
// Self-checking bench for seq_div_unit: directed corner cases plus random ops
// compared against an arithmetic reference model.
module tb_seq_div_unit;
   localparam int W = 64;
   localparam logic [W-1:0] ONES = '1;
   localparam logic [W-1:0] MINN = 64'h8000_0000_0000_0000;

   logic clk = 1'b0;
   logic rst, start, is_signed, rem_sel, flush;
   logic [W-1:0] op1, op2, result;
   logic ready, done;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   seq_div_unit #(.WIDTH(W), .CNT_W(7)) dut (
      .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
      .rem_sel(rem_sel), .op1(op1), .op2(op2), .flush(flush),
      .ready(ready), .done(done), .result(result)
   );

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit is_special(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
      return (b == 0) || (sg && a == MINN && b == ONES);
   endfunction

   // RISC-V M-extension division semantics from plain arithmetic
   function automatic logic [W-1:0] model(input bit sg, input bit rs,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
      longint sa, sb;
      if (b == 0) return rs ? a : ONES;
      if (sg && a == MINN && b == ONES) return rs ? '0 : a;
      if (sg) begin
         sa = a; sb = b;
         return rs ? W'(sa % sb) : W'(sa / sb);
      end
      return rs ? (a % b) : (a / b);
   endfunction

   // Issue one op; report result, done latency (cycle count from accept) and cycles with ready high
   task automatic do_op(input bit sg, input bit rs, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit hold, output logic [W-1:0] res, output int lat, output int rdy_hi);
      @(negedge clk);
      start = 1'b1; is_signed = sg; rem_sel = rs; op1 = a; op2 = b;
      @(posedge clk);
      #1 if (!hold) start = 1'b0;
      lat = 0; rdy_hi = 0;
      do begin
         @(negedge clk);
         lat++;
         if (ready) rdy_hi++;
      end while (!done && lat < 200);
      start = 1'b0;
      res = result;
   endtask

   task automatic run_check(input string tag, input bit sg, input bit rs,
                            input logic [W-1:0] a, input logic [W-1:0] b, input bit hold);
      logic [W-1:0] res;
      int lat, rdy_hi, exp_lat;
      exp_lat = is_special(sg, a, b) ? 1 : W + 2;
      do_op(sg, rs, a, b, hold, res, lat, rdy_hi);
      chk({tag, " result"}, res, model(sg, rs, a, b));
      chk({tag, " latency"}, W'(lat), W'(exp_lat));
      chk({tag, " ready_low"}, W'(rdy_hi), '0);
   endtask

   initial begin
      logic [W-1:0] a, b, prev;
      int dn, rb;
      bit sg, rs;

      rst = 1'b1; start = 1'b0; is_signed = 1'b0; rem_sel = 1'b0; flush = 1'b0;
      op1 = '0; op2 = '0;
      repeat (2) @(negedge clk);
      chk("reset ready", W'(ready), W'(1));
      chk("reset done", W'(done), '0);
      chk("reset result", result, '0);
      rst = 1'b0;

      // Directed cases; first one holds start high throughout to catch re-accepts
      run_check("u100/7 q", 1'b0, 1'b0, 64'd100, 64'd7, 1'b1);
      run_check("u100/7 r", 1'b0, 1'b1, 64'd100, 64'd7, 1'b0);
      run_check("s-7/2 q", 1'b1, 1'b0, -64'sd7, 64'd2, 1'b0);
      run_check("s-7/2 r", 1'b1, 1'b1, -64'sd7, 64'd2, 1'b0);
      run_check("s7/-2 q", 1'b1, 1'b0, 64'd7, -64'sd2, 1'b0);
      run_check("s7/-2 r", 1'b1, 1'b1, 64'd7, -64'sd2, 1'b0);
      run_check("s5/0 q", 1'b1, 1'b0, 64'd5, 64'd0, 1'b0);
      run_check("s5/0 r", 1'b1, 1'b1, 64'd5, 64'd0, 1'b0);
      run_check("u5/0 q", 1'b0, 1'b0, 64'd5, 64'd0, 1'b0);
      run_check("u5/0 r", 1'b0, 1'b1, 64'd5, 64'd0, 1'b0);
      run_check("sovf q", 1'b1, 1'b0, MINN, ONES, 1'b0);
      run_check("sovf r", 1'b1, 1'b1, MINN, ONES, 1'b0);
      run_check("uovf q", 1'b0, 1'b0, MINN, ONES, 1'b0);
      run_check("uovf r", 1'b0, 1'b1, MINN, ONES, 1'b0);

      // Random ops: mix of full-width and small divisors, occasional zero
      for (int i = 0; i < 24; i++) begin
         sg = 1'($urandom);
         rs = 1'($urandom);
         a = {$urandom, $urandom};
         case ($urandom_range(3))
            0: b = {$urandom, $urandom};
            1: b = W'($urandom_range(1, 1000));
            2: b = -W'($urandom_range(1, 1000));
            default: b = (i % 2) ? '0 : W'($urandom);
         endcase
         run_check($sformatf("rand%0d", i), sg, rs, a, b, 1'b0);
      end

      // Flush at cycle 30 with start held high during CALC
      prev = result;
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; rem_sel = 1'b0; op1 = 64'd999999; op2 = 64'd13;
      @(posedge clk);
      dn = 0; rb = 0;
      for (int c = 1; c < 30; c++) begin
         @(negedge clk);
         if (done) dn++;
         if (ready) rb++;
      end
      @(negedge clk);
      flush = 1'b1; start = 1'b0;
      if (done) dn++;
      @(negedge clk);
      flush = 1'b0;
      chk("flush ready_low_before", W'(rb), '0);
      chk("flush ready_after", W'(ready), W'(1));
      chk("flush no_done", W'(dn + int'(done)), '0);
      chk("flush result_kept", result, prev);

      // flush and start together in IDLE: nothing accepted
      start = 1'b1; flush = 1'b1; op1 = 64'd1; op2 = 64'd1;
      @(negedge clk);
      start = 1'b0; flush = 1'b0;
      chk("flush+start ready", W'(ready), W'(1));
      chk("flush+start done", W'(done), '0);

      run_check("u ones/3 q", 1'b0, 1'b0, ONES, 64'd3, 1'b0);

      // Async reset in the middle of CALC
      @(negedge clk);
      start = 1'b1; is_signed = 1'b0; rem_sel = 1'b0; op1 = 64'd12345; op2 = 64'd7;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (20) @(negedge clk);
      rst = 1'b1;
      #1;
      chk("midreset ready", W'(ready), W'(1));
      chk("midreset done", W'(done), '0);
      chk("midreset result", result, '0);
      @(negedge clk);
      rst = 1'b0;
      dn = 0;
      repeat (70) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("midreset no_done", W'(dn), '0);
      run_check("u1/1 q", 1'b0, 1'b0, 64'd1, 64'd1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/seq_div_unit.md
Name: seq_div_unit

Overview:
- Multi-cycle radix-2 restoring integer divider for the multiplication/division unit; the division counterpart of the multiplier datapath.
- Computes RV64M DIV/DIVU/REM/REMU semantics one quotient bit per clock, using one (WIDTH+1)-bit trial subtract per cycle.
- Sits beside the multiplier and uses a start/ready/done handshake toward the execute stage.

Parameters:
- WIDTH, 64, operand/result width in bits; even, >= 8.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; accepted only when start & ready.
- is_signed  input  1  1 = DIV/REM (two's complement), 0 = DIVU/REMU; sampled at accept.
- rem_sel  input  1  1 = return remainder, 0 = return quotient; sampled at accept.
- op1  input  WIDTH  dividend; sampled at accept.
- op2  input  WIDTH  divisor; sampled at accept.
- flush  input  1  synchronous abort.
- ready  output  1  high only in IDLE.
- done  output  1  one-cycle pulse; result valid in that cycle.
- result  output  WIDTH  quotient or remainder; holds its value until the next done.

Behaviour:
- Reset (async, immediate): state = IDLE, ready = 1, done = 0, result = 0, counter = 0, internal registers = 0.
- States are IDLE, CALC, FIX and DONE.
- IDLE transitions on accept, decided from the sampled operands:
  - op2 == 0 -> DONE; quotient = all ones, remainder = op1.
  - is_signed, op1 == 1 followed by WIDTH-1 zeros, and op2 == all ones -> DONE; quotient = op1, remainder = 0.
  - Otherwise: latch the magnitudes (|op| if is_signed, else raw). Latch neg_q = is_signed & (op1[MSB] ^ op2[MSB]) and neg_r = is_signed & op1[MSB]. Clear the partial remainder, load counter = WIDTH, go to CALC.
- CALC, one step per cycle:
  - r' = {r, q[MSB]} and q shifts left.
  - diff = r' - divisor, computed in WIDTH+1 bits.
  - If diff is non-negative: r = diff and q[0] = 1. Else: r = r' and q[0] = 0.
  - Counter decrements; when the counter reaches 1 in this cycle, go to FIX.
- FIX: quotient = neg_q ? -q : q; remainder = neg_r ? -r : r (two's-complement negate, wraps in WIDTH bits). Go to DONE.
- DONE: done = 1 and result = rem_sel ? remainder : quotient, both registered. Go to IDLE; ready rises in the next cycle.
- Latency, counted from the accept edge:
  - Normal path: done is high in cycle WIDTH+2 (66 for WIDTH = 64).
  - Special cases (op2 == 0, signed overflow): done is high in cycle 1.
- Handshake rules:
  - start while not ready is ignored, not queued.
  - start may stay high through DONE; a new accept occurs only after the return to IDLE.
- flush, in any state: go to IDLE at the next edge. done stays 0, result is unchanged, in-flight data is discarded.
- flush and start in the same IDLE cycle: flush wins and nothing is accepted.
- Reset mid-operation: async clear; no done is produced for the aborted operation.
- Unsigned arithmetic uses the raw WIDTH-bit values; no sign extension.

Test Plan:
- Unsigned 100/7 (is_signed = 0):
  - rem_sel = 0 -> result = 14, done exactly 66 cycles after accept.
  - rem_sel = 1 -> result = 2.
  - ready is low throughout.
- Signed -7/2:
  - Quotient -> 0xFFFF_FFFF_FFFF_FFFD; remainder -> 0xFFFF_FFFF_FFFF_FFFF.
  - Signed 7/-2 -> quotient -3, remainder +1.
- Divide by zero, signed and unsigned 5/0:
  - Quotient = 0xFFFF_FFFF_FFFF_FFFF; remainder = 5.
  - done in cycle 1 after accept.
- Signed overflow 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF:
  - Quotient = 0x8000_0000_0000_0000; remainder = 0; done in cycle 1.
  - Same operands unsigned -> quotient 0, remainder 0x8000_0000_0000_0000 after 66 cycles.
- Flush and ignored start:
  - Start held high during CALC -> no second accept.
  - flush at cycle 30 -> no done; ready = 1 in the next cycle; result keeps its previous value.
  - A new 0xFFFF_FFFF_FFFF_FFFF/3 unsigned -> quotient 0x5555_5555_5555_5555.
- Reset in CALC (cycle 20):
  - ready = 1, done = 0 and result = 0 immediately, without waiting for a clock edge.
  - After release, 1/1 -> quotient 1.
